// File: rtl/m3_rampspeedpowerctrl_if.sv
// m3_rampspeedpowerctrl_if
// Command/status bundle between the key-debounce logic, the ramp speed/power
// controller and the step/commutation generator.
//   commands (master -> slave): m3startI, m3forceStopI, m3invRotateI,
//                               m3speedINCi, m3speedDECi, m3powerINCi, m3powerDECi
//   status   (slave -> master): tickO, workingO, dirO, roundLenO, dstRoundLenO,
//                               powerO, atSpeedO, stateO
interface m3_rampspeedpowerctrl_if #(
    parameter int LEN_W = 32,
    parameter int PWR_W = 8
);
    logic             m3startI;
    logic             m3forceStopI;
    logic             m3invRotateI;
    logic             m3speedINCi;
    logic             m3speedDECi;
    logic             m3powerINCi;
    logic             m3powerDECi;

    logic             tickO;
    logic             workingO;
    logic             dirO;
    logic [LEN_W-1:0] roundLenO;
    logic [LEN_W-1:0] dstRoundLenO;
    logic [PWR_W-1:0] powerO;
    logic             atSpeedO;
    logic [1:0]       stateO;

    modport master (
        output m3startI, m3forceStopI, m3invRotateI,
               m3speedINCi, m3speedDECi, m3powerINCi, m3powerDECi,
        input  tickO, workingO, dirO, roundLenO, dstRoundLenO,
               powerO, atSpeedO, stateO
    );

    modport slave (
        input  m3startI, m3forceStopI, m3invRotateI,
               m3speedINCi, m3speedDECi, m3powerINCi, m3powerDECi,
        output tickO, workingO, dirO, roundLenO, dstRoundLenO,
               powerO, atSpeedO, stateO
    );
endinterface

// File: rtl/m3_rampspeedpowerctrl.sv
// m3_rampspeedpowerctrl
// Speed/power controller for one three-phase motor channel. Keeps a target
// round length and a power level, and ramps the actual round length toward
// the target once per slow tick. Reversal and soft stop first decelerate to
// the slowest round length.
// Ports:
//   clkI  - system clock
//   rstI  - asynchronous active-high reset
//   bus   - slave side of m3_rampspeedpowerctrl_if (command pulses in,
//           tick/state/length/power status out)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE  (0) | motor off, round length pinned to LEN_MAX, divider held at 0
// RUN   (1) | ramp actual round length toward the target
// REVERSE(2)| ramp to LEN_MAX, then flip direction and return to RUN
// STOP  (3) | ramp to LEN_MAX, then drop to IDLE
module m3_rampspeedpowerctrl #(
    parameter int CLK_DIV   = 10000,
    parameter int LEN_W     = 32,
    parameter int LEN_MIN   = 100,
    parameter int LEN_MAX   = 100000,
    parameter int LEN_STEP  = 1000,
    parameter int RAMP_STEP = 500,
    parameter int PWR_W     = 8,
    parameter int PWR_MAX   = 255,
    parameter int PWR_STEP  = 8,
    parameter int PWR_INIT  = 64
) (
    input  logic                    clkI,
    input  logic                    rstI,
    m3_rampspeedpowerctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_REVERSE = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [LEN_W-1:0] L_MIN   = LEN_W'(LEN_MIN);
    localparam logic [LEN_W-1:0] L_MAX   = LEN_W'(LEN_MAX);
    localparam logic [LEN_W-1:0] L_STEP  = LEN_W'(LEN_STEP);
    localparam logic [LEN_W-1:0] L_RAMP  = LEN_W'(RAMP_STEP);
    localparam logic [LEN_W:0]   LX_STEP = (LEN_W+1)'(LEN_STEP);
    localparam logic [LEN_W:0]   LX_MAX  = (LEN_W+1)'(LEN_MAX);
    localparam logic [LEN_W:0]   LX_INCF = (LEN_W+1)'(LEN_MIN + LEN_STEP);

    localparam logic [PWR_W-1:0] P_MAX   = PWR_W'(PWR_MAX);
    localparam logic [PWR_W-1:0] P_STEP  = PWR_W'(PWR_STEP);
    localparam logic [PWR_W-1:0] P_INIT  = PWR_W'(PWR_INIT);
    localparam logic [PWR_W:0]   PX_STEP = (PWR_W+1)'(PWR_STEP);
    localparam logic [PWR_W:0]   PX_MAX  = (PWR_W+1)'(PWR_MAX);

    state_t             state_q, state_d, cmd_state;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   dst_q, dst_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [LEN_W-1:0]   ramp_goal, ramp_len;
    logic [LEN_W:0]     dst_sum;
    logic [PWR_W:0]     pwr_sum;

    // State register (and the datapath registers that move with it)
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            div_q   <= '0;
            len_q   <= L_MAX;
            dst_q   <= L_MAX;
            pwr_q   <= P_INIT;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            pwr_q   <= pwr_d;
        end
    end

    // Next-state logic. Commands pick the state first; the ramp step then
    // uses that state's goal, and only a command-free tick may complete a
    // REVERSE or STOP deceleration.
    always_comb begin
        cmd_state = state_q;
        dir_d     = dir_q;
        if (bus.m3forceStopI) begin
            cmd_state = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.m3startI)          cmd_state = S_RUN;
                    else if (bus.m3invRotateI) dir_d     = ~dir_q;
                end
                S_RUN: begin
                    if (bus.m3startI)          cmd_state = S_STOP;
                    else if (bus.m3invRotateI) cmd_state = S_REVERSE;
                end
                S_REVERSE: if (bus.m3startI)   cmd_state = S_STOP;
                S_STOP:    if (bus.m3startI)   cmd_state = S_RUN;
                default:                       cmd_state = S_IDLE;
            endcase
        end

        ramp_goal = (cmd_state == S_RUN) ? dst_q : L_MAX;

        // Direction from the unsigned compare, then magnitude against the step,
        // so the length never overshoots or wraps.
        ramp_len = len_q;
        if (len_q < ramp_goal) begin
            if ((ramp_goal - len_q) <= L_RAMP) ramp_len = ramp_goal;
            else                                ramp_len = len_q + L_RAMP;
        end else if (len_q > ramp_goal) begin
            if ((len_q - ramp_goal) <= L_RAMP) ramp_len = ramp_goal;
            else                                ramp_len = len_q - L_RAMP;
        end

        state_d = cmd_state;
        if (tick_q && (cmd_state == state_q) && (ramp_len == L_MAX)) begin
            if (state_q == S_REVERSE) begin
                state_d = S_RUN;
                dir_d   = ~dir_q;
            end else if (state_q == S_STOP) begin
                state_d = S_IDLE;
            end
        end
    end

    // Datapath next values
    always_comb begin
        len_d = len_q;
        if (bus.m3forceStopI || (state_q == S_IDLE)) len_d = L_MAX;
        else if (tick_q)                              len_d = ramp_len;

        // Divider only runs while active and restarts from 0 whenever the
        // channel drops back to IDLE.
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) div_d = '0;
        else if (div_q == DIV_LAST)                       div_d = '0;
        else                                              div_d = div_q + DIV_W'(1);
        tick_d = (state_q != S_IDLE) && (state_d != S_IDLE) && (div_q == DIV_LAST);

        dst_sum = {1'b0, dst_q} + LX_STEP;
        dst_d   = dst_q;
        if (bus.m3speedINCi && !bus.m3speedDECi) begin
            dst_d = ({1'b0, dst_q} <= LX_INCF) ? L_MIN : (dst_q - L_STEP);
        end else if (bus.m3speedDECi && !bus.m3speedINCi) begin
            dst_d = (dst_sum >= LX_MAX) ? L_MAX : dst_sum[LEN_W-1:0];
        end

        pwr_sum = {1'b0, pwr_q} + PX_STEP;
        pwr_d   = pwr_q;
        if (bus.m3powerINCi && !bus.m3powerDECi) begin
            pwr_d = (pwr_sum >= PX_MAX) ? P_MAX : pwr_sum[PWR_W-1:0];
        end else if (bus.m3powerDECi && !bus.m3powerINCi) begin
            pwr_d = ({1'b0, pwr_q} < PX_STEP) ? '0 : (pwr_q - P_STEP);
        end
    end

    // Outputs
    always_comb begin
        bus.tickO        = tick_q;
        bus.workingO     = (state_q != S_IDLE);
        bus.dirO         = dir_q;
        bus.roundLenO    = len_q;
        bus.dstRoundLenO = dst_q;
        bus.powerO       = pwr_q;
        bus.atSpeedO     = (state_q == S_RUN) && (len_q == dst_q);
        bus.stateO       = state_q;
    end
endmodule
